// File: rtl/batcharger_pkg.sv
// Shared channel codes, FSM encoding and channel-selection helper for the
// battery-charger ADC sequencer.
package batcharger_pkg;

   localparam logic [1:0] CH_T = 2'b00;
   localparam logic [1:0] CH_V = 2'b01;
   localparam logic [1:0] CH_I = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_START,
      S_CONV,
      S_UPDATE
   } state_e;

   typedef struct packed {
      logic       found;
      logic [1:0] ch;
   } ch_sel_t;

   function automatic logic [1:0] ch_inc(input logic [1:0] ch);
      return (ch == CH_I) ? CH_T : ch + 2'd1;
   endfunction

   // Cyclic search starting after cur; cur itself is tried last so a lone
   // enabled channel keeps being selected. men is indexed by channel code.
   function automatic ch_sel_t next_ch(input logic [1:0] cur, input logic [2:0] men);
      ch_sel_t    r;
      logic [1:0] c;
      r = '0;
      c = cur;
      for (int i = 0; i < 3; i++) begin
         c = ch_inc(c);
         if (!r.found && men[c]) begin
            r.found = 1'b1;
            r.ch    = c;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/batcharger_adc_avg.sv
// Per-channel sample accumulator: sums 2^AVG_LOG2 conversions and presents
// the truncated mean. done flags the sample that completes a batch.
module batcharger_adc_avg #(
   parameter int AVG_LOG2 = 2
) (
   input  logic       clk,
   input  logic       rstz,
   input  logic       clr,
   input  logic       sample_vld,
   input  logic [7:0] data,
   output logic       done,
   output logic [7:0] avg
);
   localparam int AW = 8 + AVG_LOG2;

   logic [AW-1:0]     acc_q, acc_d;
   logic [AVG_LOG2:0] cnt_q, cnt_d;

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (clr) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (sample_vld) begin
         acc_d = acc_q + AW'(data);
         cnt_d = cnt_q + (AVG_LOG2 + 1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   assign done = sample_vld && (cnt_q == (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1));
   // acc >> AVG_LOG2 is exactly the top 8 bits of the accumulator
   assign avg  = acc_q[AW-1 -: 8];

endmodule

// File: rtl/batcharger_adc_sequencer.sv
// Time-multiplexes the shared ADC over T/V/I channels, averages each channel
// and publishes tbat/vbat/ibat plus the vtok and sticky timeout flags.
module batcharger_adc_sequencer
   import batcharger_pkg::*;
#(
   parameter int SETTLE_CYC  = 4,
   parameter int AVG_LOG2    = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic       clk,
   input  logic       rstz,
   input  logic       en,
   input  logic       tmonen,
   input  logic       vmonen,
   input  logic       imonen,
   output logic [1:0] adc_ch,
   output logic       adc_start,
   input  logic       adc_done,
   input  logic [7:0] adc_data,
   output logic [7:0] tbat,
   output logic [7:0] vbat,
   output logic [7:0] ibat,
   output logic       vtok,
   output logic       adc_err
);
   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] ch_q, ch_d;
   logic       disc_q, disc_d, err_q, err_d, vtok_q;
   logic [2:0] vld_q, vld_d, wr_mask;
   logic [7:0] tbat_q, tbat_d, vbat_q, vbat_d, ibat_q, ibat_d;
   logic [2:0] men;
   logic       cur_en, tmo, smp, clr, wr, avg_done;
   logic [7:0] avg;
   ch_sel_t    first, nxt;

   assign men    = {imonen, vmonen, tmonen};
   assign cur_en = men[ch_q];
   assign tmo    = (cnt_q == 8'(TIMEOUT_CYC - 1));
   assign first  = next_ch(CH_I, men);
   assign nxt    = next_ch(ch_q, men);

   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!en) state_d = S_IDLE;
      else begin
         case (state_q)
            S_IDLE:   if (first.found) state_d = S_SETTLE;
            S_SETTLE: if (cnt_q == 8'(SETTLE_CYC - 1)) state_d = S_START;
            S_START:  state_d = S_CONV;
            // a dropped channel finishes its conversion, then gives up the ADC
            S_CONV:   if (adc_done) state_d = (avg_done || !cur_en) ? S_UPDATE : S_START;
                      else if (tmo) state_d = S_UPDATE;
            S_UPDATE: state_d = nxt.found ? S_SETTLE : S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      adc_start = (state_q == S_START);
      smp       = (state_q == S_CONV) && adc_done && en;
      clr       = !en || (state_q == S_UPDATE);
      wr        = (state_q == S_UPDATE) && !disc_q && cur_en;
   end

   always_comb begin
      cnt_d   = ((state_d == state_q) && (state_q == S_SETTLE || state_q == S_CONV))
                ? cnt_q + 8'd1 : '0;
      disc_d  = (state_q == S_CONV) && (adc_done ? !cur_en : tmo);
      err_d   = en && (err_q || ((state_q == S_CONV) && !adc_done && tmo));
      wr_mask = wr ? (3'b001 << ch_q) : 3'b000;
      vld_d   = en ? (men & (vld_q | wr_mask)) : 3'b000;
      ch_d    = ch_q;
      if (!en) ch_d = CH_T;
      else if (state_q == S_IDLE && first.found) ch_d = first.ch;
      else if (state_q == S_UPDATE && nxt.found) ch_d = nxt.ch;
      tbat_d = !en ? 8'h00 : wr_mask[CH_T] ? avg : tbat_q;
      vbat_d = !en ? 8'h00 : wr_mask[CH_V] ? avg : vbat_q;
      ibat_d = !en ? 8'h00 : wr_mask[CH_I] ? avg : ibat_q;
   end

   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         cnt_q  <= '0;
         ch_q   <= CH_T;
         disc_q <= 1'b0;
         err_q  <= 1'b0;
         vld_q  <= '0;
         vtok_q <= 1'b0;
         tbat_q <= '0;
         vbat_q <= '0;
         ibat_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         ch_q   <= ch_d;
         disc_q <= disc_d;
         err_q  <= err_d;
         vld_q  <= vld_d;
         vtok_q <= vld_d[CH_T] & vld_d[CH_V];
         tbat_q <= tbat_d;
         vbat_q <= vbat_d;
         ibat_q <= ibat_d;
      end
   end

   batcharger_adc_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
      .clk        (clk),
      .rstz       (rstz),
      .clr        (clr),
      .sample_vld (smp),
      .data       (adc_data),
      .done       (avg_done),
      .avg        (avg)
   );

   assign adc_ch  = ch_q;
   assign tbat    = tbat_q;
   assign vbat    = vbat_q;
   assign ibat    = ibat_q;
   assign vtok    = vtok_q;
   assign adc_err = err_q;

endmodule

// File: doc/batcharger_adc_sequencer.md
Name: batcharger_adc_sequencer

Overview:
Front-end for the battery charger controller. It time-multiplexes the shared 8-bit ADC across temperature, voltage and current channels, gated by the controller's tmonen/vmonen/imonen. Each channel result is averaged and registered onto the tbat/vbat/ibat buses. It raises vtok once both voltage and temperature readings are valid. It sits between the analog ADC/mux and the charger FSM.

Parameters:
SETTLE_CYC, 4, cycles adc_ch is held stable before adc_start (1..255)
AVG_LOG2, 2, log2 of samples averaged per channel update (0..4)
TIMEOUT_CYC, 64, max cycles from adc_start to adc_done before abort (2..255)

Ports:
clk  in  1  clock
rstz  in  1  asynchronous active-low reset
en  in  1  block enable
tmonen  in  1  temperature channel enable
vmonen  in  1  voltage channel enable
imonen  in  1  current channel enable
adc_ch  out  2  ADC mux select: 00=T, 01=V, 10=I
adc_start  out  1  one-cycle conversion start pulse
adc_done  in  1  one-cycle pulse; adc_data valid in the same cycle
adc_data  in  8  conversion result
tbat  out  8  averaged temperature code
vbat  out  8  averaged voltage code
ibat  out  8  averaged current code
vtok  out  1  voltage and temperature both valid
adc_err  out  1  sticky conversion-timeout flag

Behaviour:
- Reset (rstz low, async): every output is 0, FSM goes to IDLE, accumulators and valid flags are cleared.
- FSM states: IDLE, SETTLE, START, CONV, UPDATE.
- IDLE: when en=1 and any monitor enable is 1, load adc_ch with the first enabled channel in order T→V→I, then go to SETTLE.
- SETTLE: count SETTLE_CYC cycles with adc_ch stable, then go to START.
- START: adc_start=1 for exactly one cycle, then go to CONV. adc_start is 0 in every other state.
- CONV: wait for adc_done.
  - On adc_done: acc += adc_data and increment the sample count.
  - If count < 2^AVG_LOG2, go to START. No re-settle; the channel is unchanged.
  - Otherwise go to UPDATE.
- UPDATE (1 cycle):
  - Write acc >> AVG_LOG2 (truncated, 8 bits) to the channel's output register.
  - Set that channel's valid flag and clear acc and count.
  - Pick the next enabled channel cyclically after the current one. The current channel is eligible again if it is the only one enabled.
  - If a channel is found, go to SETTLE with the new adc_ch. If none, go to IDLE.
- Accumulator width is 8+AVG_LOG2 bits. It cannot overflow.
- Timeout: if CONV lasts TIMEOUT_CYC cycles without adc_done:
  - Set adc_err (sticky; cleared only by rstz or en=0).
  - Discard that channel's acc and count, leave the output register unchanged, and advance as in UPDATE without writing.
- Monitor enable dropped while its channel is active: finish the in-flight conversion (wait for done or timeout), discard the result, and advance. Its valid flag clears the cycle after the enable falls.
- Monitor enable dropped for a channel that is not active: valid flag clears, and its output register holds its last value.
- vtok is registered: vtok = t_valid & v_valid. It rises the cycle after the second of the two UPDATEs and falls the cycle after either flag clears.
- en falls: on the next edge go to IDLE, abandon any conversion (adc_done is ignored), and clear all valid flags, adc_err, acc and all output data registers.
- adc_done outside CONV is ignored.
- Enables are sampled only in IDLE and UPDATE for channel choice. Valid-flag clearing is continuous.

Decomposition:
- Package batcharger_pkg:
  - channel codes CH_T=2'b00, CH_V=2'b01, CH_I=2'b10
  - FSM state encoding
  - next-channel function
- Sub-module batcharger_adc_avg: accumulator, sample counter, and shift-divide.
  - Ports: clk, rstz, clr, sample_vld, data[7:0], done, avg[7:0].
  - Parameter: AVG_LOG2.

Test Plan:
- tmonen=1 only; ADC model returns done 10 cycles after start with data 0x50,0x52,0x54,0x56 → adc_ch=00 throughout; tbat=0x53 after UPDATE; vtok stays 0.
- tmonen=vmonen=1; T samples all 0x64, V samples all 0x93 → order T,V,T,V…; tbat=0x64, vbat=0x93; vtok rises 1 cycle after the V UPDATE.
- Steady-state T,V,I running with vtok=1; drop vmonen → vtok falls next cycle; sequence becomes T,I only; vbat holds 0x93.
- ADC model never asserts done on V → adc_start pulse followed by exactly 64 CONV cycles, then adc_err=1; vbat unchanged; sequencer advances to I.
- en falls mid-CONV, then adc_done arrives 2 cycles later → done ignored; all outputs 0 next cycle; re-enable restarts from T with a full SETTLE of 4 cycles.
- AVG_LOG2=0, SETTLE_CYC=1 → adc_ch changes, 1 settle cycle, start pulse, and the register updates with the raw sample 0xFF exactly 1 cycle after done.
